// File: rtl/core_output_ctrl.sv
// Result-edge collector: one FIFO per array column, rows released
// only once every lane holds a word, handed off over valid/ready.
module core_output_ctrl #(
   parameter int LANES = 8,
   parameter int DW    = 16,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic [DW-1:0]    res_in    [0:LANES-1],
   input  logic [0:LANES-1] res_valid,
   output logic [DW-1:0]    out_row   [0:LANES-1],
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LANES-1:0] emptys,
   output logic [LANES-1:0] fulls,
   output logic             overflow,
   output logic [15:0]      rows_out
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [AW-1:0] wp_q  [LANES];
   logic [AW-1:0] wp_d  [LANES];
   logic [AW-1:0] rp_q  [LANES];
   logic [AW-1:0] rp_d  [LANES];
   logic [CW-1:0] cnt_q [LANES];
   logic [CW-1:0] cnt_d [LANES];
   logic [DW-1:0] mem_q [LANES][DEPTH];
   logic [DW-1:0] row_q [LANES];
   logic [DW-1:0] row_d [LANES];

   logic             vld_q, vld_d;
   logic             ovf_q, ovf_d;
   logic [15:0]      rows_q, rows_d;
   logic [LANES-1:0] push;
   logic [LANES-1:0] nonempty;
   logic             row_avail;
   logic             load;
   logic             hs;

   always_comb begin
      for (int k = 0; k < LANES; k++) begin
         nonempty[k] = (cnt_q[k] != '0);
         emptys[k]   = (cnt_q[k] == '0);
         fulls[k]    = (cnt_q[k] == FULL_CNT);
      end
      row_avail = &nonempty;
      load      = row_avail && (!vld_q || out_ready);
      hs        = vld_q && out_ready;

      vld_d  = vld_q;
      ovf_d  = ovf_q;
      rows_d = rows_q;
      if (hs) rows_d = rows_q + 16'd1;
      if (load) vld_d = 1'b1;
      else if (hs) vld_d = 1'b0;

      for (int k = 0; k < LANES; k++) begin
         // a full lane still takes a word when the row pop frees a slot
         push[k] = res_valid[k] && ((cnt_q[k] != FULL_CNT) || load);
         if (res_valid[k] && !push[k]) ovf_d = 1'b1;
         wp_d[k]  = push[k] ? wp_q[k] + AW'(1) : wp_q[k];
         rp_d[k]  = load ? rp_q[k] + AW'(1) : rp_q[k];
         row_d[k] = load ? mem_q[k][rp_q[k]] : row_q[k];
         cnt_d[k] = cnt_q[k] + CW'(push[k]) - CW'(load);
      end

      if (flush) begin
         vld_d  = 1'b0;
         ovf_d  = ovf_q;
         rows_d = rows_q;
         push   = '0;
         for (int k = 0; k < LANES; k++) begin
            wp_d[k]  = '0;
            rp_d[k]  = '0;
            cnt_d[k] = '0;
            row_d[k] = row_q[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vld_q  <= 1'b0;
         ovf_q  <= 1'b0;
         rows_q <= '0;
         for (int k = 0; k < LANES; k++) begin
            wp_q[k]  <= '0;
            rp_q[k]  <= '0;
            cnt_q[k] <= '0;
            row_q[k] <= '0;
         end
      end else begin
         vld_q  <= vld_d;
         ovf_q  <= ovf_d;
         rows_q <= rows_d;
         for (int k = 0; k < LANES; k++) begin
            wp_q[k]  <= wp_d[k];
            rp_q[k]  <= rp_d[k];
            cnt_q[k] <= cnt_d[k];
            row_q[k] <= row_d[k];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int k = 0; k < LANES; k++) begin
         if (push[k] && !rst) mem_q[k][wp_q[k]] <= res_in[k];
      end
   end

   assign out_valid = vld_q;
   assign overflow  = ovf_q;
   assign rows_out  = rows_q;

   always_comb begin
      for (int k = 0; k < LANES; k++) out_row[k] = row_q[k];
   end

endmodule

// File: tb/tb_core_output_ctrl.sv
// Bench for core_output_ctrl: queue-based lane model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_core_output_ctrl;

   localparam int L = 8;
   localparam int D = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic [15:0] res_in  [0:L-1];
   logic [0:L-1] res_valid;
   logic [15:0] out_row [0:L-1];
   logic        out_valid;
   logic        out_ready;
   logic [7:0]  emptys;
   logic [7:0]  fulls;
   logic        overflow;
   logic [15:0] rows_out;

   int tests = 0;
   int fails = 0;
   bit chk_en = 1'b0;

   logic [15:0] q [L][$];
   logic [15:0] m_row [L];
   logic        m_vld;
   logic        m_ovf;
   logic [15:0] m_rows;

   core_output_ctrl #(.LANES(L), .DW(16), .DEPTH(D)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .res_in(res_in), .res_valid(res_valid),
      .out_row(out_row), .out_valid(out_valid), .out_ready(out_ready),
      .emptys(emptys), .fulls(fulls),
      .overflow(overflow), .rows_out(rows_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // reference model: lanes are plain queues, row moves when all non-empty
   always @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < L; k++) begin
            q[k].delete();
            m_row[k] = '0;
         end
         m_vld = 0; m_ovf = 0; m_rows = 0;
      end else if (flush) begin
         for (int k = 0; k < L; k++) q[k].delete();
         m_vld = 0;
      end else begin
         bit avail, ld;
         avail = 1;
         for (int k = 0; k < L; k++) if (q[k].size() == 0) avail = 0;
         ld = avail && (!m_vld || out_ready);
         if (m_vld && out_ready) m_rows = m_rows + 1;
         if (ld) for (int k = 0; k < L; k++) m_row[k] = q[k].pop_front();
         for (int k = 0; k < L; k++) begin
            if (res_valid[k]) begin
               if (q[k].size() < D) q[k].push_back(res_in[k]);
               else m_ovf = 1;
            end
         end
         if (ld) m_vld = 1;
         else if (m_vld && out_ready) m_vld = 0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         logic [7:0] e, f;
         for (int k = 0; k < L; k++) begin
            e[k] = (q[k].size() == 0);
            f[k] = (q[k].size() == D);
         end
         chk("m_valid", 32'(out_valid), 32'(m_vld));
         chk("m_emptys", 32'(emptys), 32'(e));
         chk("m_fulls", 32'(fulls), 32'(f));
         chk("m_overflow", 32'(overflow), 32'(m_ovf));
         chk("m_rows_out", 32'(rows_out), 32'(m_rows));
         for (int k = 0; k < L; k++) chk("m_row", 32'(out_row[k]), 32'(m_row[k]));
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic idle_in();
      res_valid = '0;
      for (int k = 0; k < L; k++) res_in[k] = '0;
   endtask

   task automatic push_all(input logic [15:0] v);
      res_valid = '1;
      for (int k = 0; k < L; k++) res_in[k] = v;
   endtask

   task automatic skew_fill(input logic [15:0] base);
      out_ready = 1;
      for (int k = 0; k < L; k++) begin
         idle_in();
         res_valid[k] = 1'b1;
         res_in[k] = base + 16'(k);
         step();
      end
      idle_in();
      chk("skew_not_yet", 32'(out_valid), 32'd0);
      step();
      chk("skew_valid", 32'(out_valid), 32'd1);
      for (int k = 0; k < L; k++) chk("skew_row", 32'(out_row[k]), 32'(base + 16'(k)));
      step();
      chk("skew_drained", 32'(out_valid), 32'd0);
      chk("skew_emptys", 32'(emptys), 32'hFF);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [15:0] r0;
      rst = 1; flush = 0; out_ready = 0;
      idle_in();
      step(); step();
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_emptys", 32'(emptys), 32'hFF);
      chk("rst_fulls", 32'(fulls), 32'h00);
      chk("rst_overflow", 32'(overflow), 32'd0);
      chk("rst_rows", 32'(rows_out), 32'd0);
      rst = 0;
      chk_en = 1;

      skew_fill(16'h0100);
      chk("skew_rows", 32'(rows_out), 32'd1);

      out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         push_all(16'(i));
         step();
         if (i >= 1) begin
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_row", 32'(out_row[i % L]), 32'(i - 1));
         end
      end
      idle_in();
      step();
      chk("stream_last", 32'(out_row[0]), 32'd15);
      step(); step();
      chk("stream_rows", 32'(rows_out), 32'd17);
      chk("stream_ovf", 32'(overflow), 32'd0);

      out_ready = 0;
      for (int j = 0; j < 10; j++) begin
         push_all(16'h0200 + 16'(j));
         step();
      end
      idle_in();
      chk("bp_fulls", 32'(fulls), 32'hFF);
      chk("bp_ovf", 32'(overflow), 32'd1);
      chk("bp_row0", 32'(out_row[5]), 32'h0200);
      out_ready = 1;
      for (int r = 1; r <= 8; r++) begin
         step();
         chk("bp_drain", 32'(out_row[2]), 32'h0200 + 32'(r));
      end
      step();
      chk("bp_done", 32'(out_valid), 32'd0);
      chk("bp_ovf_sticky", 32'(overflow), 32'd1);

      out_ready = 0;
      for (int j = 0; j < 9; j++) begin
         push_all(16'h0300 + 16'(j));
         step();
      end
      chk("fp_full", 32'(fulls), 32'hFF);
      out_ready = 1;
      push_all(16'hBEEF);
      step();
      idle_in();
      chk("fp_still_full", 32'(fulls), 32'hFF);
      chk("fp_row", 32'(out_row[7]), 32'h0301);
      for (int r = 2; r <= 8; r++) begin
         step();
         chk("fp_drain", 32'(out_row[1]), 32'h0300 + 32'(r));
      end
      step();
      chk("fp_beef", 32'(out_row[4]), 32'hBEEF);
      step();
      chk("fp_done", 32'(out_valid), 32'd0);

      out_ready = 0;
      for (int j = 0; j < 4; j++) begin
         push_all(16'h0400 + 16'(j));
         step();
      end
      idle_in();
      chk("fl_pre_valid", 32'(out_valid), 32'd1);
      r0 = rows_out;
      flush = 1; out_ready = 1;
      push_all(16'hDEAD);
      step();
      flush = 0;
      idle_in();
      chk("fl_valid", 32'(out_valid), 32'd0);
      chk("fl_emptys", 32'(emptys), 32'hFF);
      chk("fl_rows", 32'(rows_out), 32'(r0));
      skew_fill(16'h0500);

      for (int i = 0; i < 3000; i++) begin
         int rp;
         rp = (i / 300) % 2 == 0 ? 85 : 20;
         for (int k = 0; k < L; k++) res_in[k] = 16'($urandom);
         res_valid = L'($urandom) | L'($urandom);
         out_ready = ($urandom_range(0, 99) < rp);
         flush = ($urandom_range(0, 99) == 0);
         rst = ($urandom_range(0, 499) == 0);
         step();
      end
      rst = 0; flush = 0;
      idle_in();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
